// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: state encoding and default sizing shared by the DataRAM controller
package data_ram_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int LENGTH_DEF = 8;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;
endpackage

// File: rtl/data_ram_ctrl_if.sv
// data_ram_ctrl_if: request/response handshake plus DataRAM port; master is the controller side
interface data_ram_ctrl_if import data_ram_ctrl_pkg::*; #(
  parameter int width = WIDTH_DEF,
  parameter int length = LENGTH_DEF
);
  logic reqValid;
  logic reqReady;
  logic reqWrite;
  logic reqIndirect;
  logic [length-1:0] reqAddr;
  logic [width-1:0] reqData;
  logic respValid;
  logic respError;
  logic [width-1:0] respData;
  logic memIndirect;
  logic memWriteEnable;
  logic memReadEnable;
  logic [length-1:0] memAddr;
  logic [width-1:0] memWriteData;
  logic memDataReady;
  logic [width-1:0] memReadData;
  modport master (
    input  reqValid, reqWrite, reqIndirect, reqAddr, reqData, memDataReady, memReadData,
    output reqReady, respValid, respError, respData,
           memIndirect, memWriteEnable, memReadEnable, memAddr, memWriteData
  );
  modport slave (
    output reqValid, reqWrite, reqIndirect, reqAddr, reqData, memDataReady, memReadData,
    input  reqReady, respValid, respError, respData,
           memIndirect, memWriteEnable, memReadEnable, memAddr, memWriteData
  );
endinterface

// File: rtl/data_ram_ctrl_wait_timer.sv
// wait_timer: saturating up-counter with synchronous clear and enable; expired once it reaches max
module wait_timer #(
  parameter int max = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(max + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(max);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: sequences DataRAM strobes for one read/write request at a time, with read timeout
module data_ram_ctrl import data_ram_ctrl_pkg::*; #(
  parameter int timeout = TIMEOUT_DEF
) (
  input logic clk,
  input logic clr,
  data_ram_ctrl_if.master bus
);
  state_t state;
  logic expired;
  wait_timer #(.max(timeout)) u_timer (
    .clk(clk),
    .clr(clr || state != READ_WAIT),
    .en(state == READ_WAIT && !bus.memDataReady),
    .expired(expired)
  );
  assign bus.reqReady = state == IDLE && !clr;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      bus.memWriteEnable <= 1'b0;
      bus.memReadEnable <= 1'b0;
      bus.memIndirect <= 1'b0;
      bus.memAddr <= '0;
      bus.memWriteData <= '0;
      bus.respValid <= 1'b0;
      bus.respError <= 1'b0;
      bus.respData <= '0;
    end else begin
      bus.memWriteEnable <= 1'b0;
      bus.memReadEnable <= 1'b0;
      bus.memIndirect <= 1'b0;
      bus.respValid <= 1'b0;
      case (state)
        IDLE: if (bus.reqValid) begin
          state <= bus.reqWrite ? WRITE : READ_REQ;
          bus.memAddr <= bus.reqAddr;
          bus.memWriteData <= bus.reqData;
          bus.memWriteEnable <= bus.reqWrite;
          bus.memReadEnable <= !bus.reqWrite;
          bus.memIndirect <= !bus.reqWrite && bus.reqIndirect;
          bus.respError <= 1'b0;
        end
        WRITE: begin
          state <= RESP;
          bus.respValid <= 1'b1;
        end
        READ_REQ: state <= READ_WAIT;
        READ_WAIT: if (bus.memDataReady || expired) begin
          state <= RESP;
          bus.respValid <= 1'b1;
          bus.respError <= !bus.memDataReady;
          bus.respData <= bus.memDataReady ? bus.memReadData : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed checks of write, direct/indirect read, timeout, backpressure and reset
module tb_data_ram_ctrl;
  logic clk = 1'b0;
  logic clr;
  logic dead, late;
  logic rdy_q;
  logic [7:0] rd_q;
  logic [7:0] ram [256];
  int checks = 0;
  int errors = 0;
  int acc = 0;
  int acc0;
  data_ram_ctrl_if #(.width(8), .length(8)) bus ();
  data_ram_ctrl #(.timeout(4)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.memWriteEnable) ram[bus.memAddr] <= bus.memWriteData;
    rdy_q <= bus.memReadEnable && !dead;
    rd_q <= bus.memIndirect ? ram[ram[bus.memAddr]] : ram[bus.memAddr];
    if (bus.reqValid && bus.reqReady) acc <= acc + 1;
  end
  assign bus.memDataReady = rdy_q || late;
  assign bus.memReadData = rd_q;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue(input logic w, input logic ind, input logic [7:0] a, input logic [7:0] d);
    chk("accept_ready", bus.reqReady, 1);
    bus.reqValid = 1'b1;
    bus.reqWrite = w;
    bus.reqIndirect = ind;
    bus.reqAddr = a;
    bus.reqData = d;
    step(1);
    bus.reqValid = 1'b0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    issue(1'b1, 1'b0, a, d);
    step(2);
  endtask
  initial begin
    clr = 1'b1;
    dead = 1'b0;
    late = 1'b0;
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.reqIndirect = 1'b0;
    bus.reqAddr = '0;
    bus.reqData = '0;
    step(1);
    chk("rst_ready_low", bus.reqReady, 0);
    step(1);
    chk("rst_we", bus.memWriteEnable, 0);
    chk("rst_re", bus.memReadEnable, 0);
    chk("rst_resp_valid", bus.respValid, 0);
    chk("rst_resp_error", bus.respError, 0);
    chk("rst_resp_data", bus.respData, 0);
    chk("rst_addr", bus.memAddr, 0);
    chk("rst_wdata", bus.memWriteData, 0);
    clr = 1'b0;
    step(1);
    chk("ready_after_rst", bus.reqReady, 1);
    issue(1'b1, 1'b0, 8'h12, 8'hA5);
    chk("wr_c1_we", bus.memWriteEnable, 1);
    chk("wr_c1_re", bus.memReadEnable, 0);
    chk("wr_c1_addr", bus.memAddr, 8'h12);
    chk("wr_c1_wdata", bus.memWriteData, 8'hA5);
    chk("wr_c1_valid", bus.respValid, 0);
    step(1);
    chk("wr_c2_we", bus.memWriteEnable, 0);
    chk("wr_c2_valid", bus.respValid, 1);
    chk("wr_c2_error", bus.respError, 0);
    step(1);
    chk("wr_c3_valid", bus.respValid, 0);
    chk("wr_c3_ready", bus.reqReady, 1);
    issue(1'b0, 1'b0, 8'h12, 8'h00);
    chk("rd_c1_re", bus.memReadEnable, 1);
    chk("rd_c1_we", bus.memWriteEnable, 0);
    chk("rd_c1_ind", bus.memIndirect, 0);
    chk("rd_c1_addr", bus.memAddr, 8'h12);
    step(1);
    chk("rd_c2_re", bus.memReadEnable, 0);
    chk("rd_c2_valid", bus.respValid, 0);
    step(1);
    chk("rd_c3_valid", bus.respValid, 1);
    chk("rd_c3_data", bus.respData, 8'hA5);
    chk("rd_c3_error", bus.respError, 0);
    step(1);
    chk("rd_c4_valid", bus.respValid, 0);
    wr(8'h20, 8'h30);
    wr(8'h30, 8'h7E);
    issue(1'b0, 1'b1, 8'h20, 8'h00);
    chk("ind_c1_ind", bus.memIndirect, 1);
    chk("ind_c1_re", bus.memReadEnable, 1);
    step(1);
    chk("ind_c2_ind", bus.memIndirect, 0);
    step(1);
    chk("ind_c3_valid", bus.respValid, 1);
    chk("ind_c3_data", bus.respData, 8'h7E);
    step(1);
    dead = 1'b1;
    issue(1'b0, 1'b0, 8'h12, 8'h00);
    step(5);
    chk("to_c6_valid", bus.respValid, 0);
    step(1);
    chk("to_c7_valid", bus.respValid, 1);
    chk("to_c7_error", bus.respError, 1);
    chk("to_c7_data", bus.respData, 0);
    step(1);
    chk("to_c8_ready", bus.reqReady, 1);
    chk("to_c8_valid", bus.respValid, 0);
    chk("to_c8_error_held", bus.respError, 1);
    dead = 1'b0;
    acc0 = acc;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b0;
    bus.reqIndirect = 1'b0;
    bus.reqAddr = 8'h30;
    step(1);
    chk("bp_c1_re", bus.memReadEnable, 1);
    chk("bp_c1_error_clr", bus.respError, 0);
    step(1);
    chk("bp_c2_ready", bus.reqReady, 0);
    chk("bp_c2_re", bus.memReadEnable, 0);
    step(1);
    chk("bp_c3_valid", bus.respValid, 1);
    chk("bp_c3_data", bus.respData, 8'h7E);
    chk("bp_c3_re", bus.memReadEnable, 0);
    bus.reqValid = 1'b0;
    chk("bp_accepts", acc - acc0, 1);
    step(1);
    dead = 1'b1;
    issue(1'b0, 1'b0, 8'h12, 8'h00);
    step(1);
    clr = 1'b1;
    step(1);
    chk("clr_re", bus.memReadEnable, 0);
    chk("clr_we", bus.memWriteEnable, 0);
    chk("clr_valid", bus.respValid, 0);
    chk("clr_ready", bus.reqReady, 0);
    clr = 1'b0;
    dead = 1'b0;
    late = 1'b1;
    step(1);
    late = 1'b0;
    chk("late_valid", bus.respValid, 0);
    chk("late_data", bus.respData, 0);
    chk("late_ready", bus.reqReady, 1);
    step(1);
    chk("late_valid2", bus.respValid, 0);
    chk("late_addr", bus.memAddr, 0);
    wr(8'h44, 8'h5A);
    issue(1'b0, 1'b0, 8'h44, 8'h00);
    step(2);
    chk("rec_valid", bus.respValid, 1);
    chk("rec_data", bus.respData, 8'h5A);
    step(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
